psk_modulator: RTL and testbench

- Transmit end of the 1-bit PSK correlator link. Accepts bytes over a valid/ready handshake and emits a 1-bit square-wave carrier `sig` from an internal NCO.
- Modulation is differential BPSK: a 1 bit flips the carrier phase by 180°, a 0 bit leaves it unchanged.
- Each frame carries a phase-reference preamble, start symbol, 8 data symbols and a stop symbol. This lets the receive-side I/Q correlators lock phase before data.
- Sits between the byte source (UART/FIFO) and the output pin or loopback into the receiver.

---
 rtl/psk_modulator.sv | 147 ++++++++++++++
 tb/tb_psk_modulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/psk_modulator.sv
// Differential BPSK transmitter: frames each byte as preamble, start, 8 data
// symbols (LSB first) and stop, and drives a square-wave NCO carrier on sig.
module psk_modulator #(
   parameter int PHASE_W       = 13,
   parameter int FCW           = 512,
   parameter int SYMBOL_CYCLES = 256,
   parameter int PREAMBLE_SYMS = 4
) (
   input  logic       clk,
   input  logic       rst_in,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       sig,
   output logic       busy,
   output logic       sym_stb
);

   localparam int SYM_W = $clog2(SYMBOL_CYCLES);
   localparam int PRE_W = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
   localparam logic [SYM_W-1:0]   SYM_LAST = SYM_W'(SYMBOL_CYCLES - 1);
   localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PREAMBLE_SYMS - 1);
   localparam logic [PHASE_W-1:0] FCW_V    = PHASE_W'(FCW);
   localparam logic [PHASE_W-1:0] PI_V     = {1'b1, {(PHASE_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      START    = 3'd2,
      DATA     = 3'd3,
      STOP     = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic [PHASE_W-1:0] acc, acc_nx;
   logic [PHASE_W-1:0] pcw, pcw_nx;
   logic [PHASE_W-1:0] phase_sum;
   logic [SYM_W-1:0]   sym_cnt, sym_nx;
   logic [2:0]         bit_cnt, bit_nx;
   logic [PRE_W-1:0]   pre_cnt, pre_nx;
   logic [7:0]         shift, shift_nx;
   logic               sig_nx;
   logic               sym_end;
   logic               accept;

   assign sym_end   = (sym_cnt == SYM_LAST);
   assign ready     = rst_in && ((state == IDLE) || ((state == STOP) && sym_end));
   assign accept    = valid && ready;
   assign busy      = (state != IDLE);
   assign sym_stb   = busy && (sym_cnt == '0);
   assign phase_sum = acc + pcw;

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state   <= IDLE;
         acc     <= '0;
         pcw     <= '0;
         sym_cnt <= '0;
         bit_cnt <= '0;
         pre_cnt <= '0;
         shift   <= '0;
         sig     <= 1'b0;
      end else begin
         state   <= state_nx;
         acc     <= acc_nx;
         pcw     <= pcw_nx;
         sym_cnt <= sym_nx;
         bit_cnt <= bit_nx;
         pre_cnt <= pre_nx;
         shift   <= shift_nx;
         sig     <= sig_nx;
      end
   end

   // Phase updates land on the symbol-end edge so they apply from sym_cnt==0.
   always_comb begin
      state_nx = state;
      acc_nx   = acc + FCW_V;
      pcw_nx   = pcw;
      sym_nx   = sym_cnt;
      bit_nx   = bit_cnt;
      pre_nx   = pre_cnt;
      shift_nx = shift;
      sig_nx   = 1'b0;

      if (state != IDLE) begin
         sig_nx = phase_sum[PHASE_W-1];
         sym_nx = sym_end ? '0 : sym_cnt + SYM_W'(1);
      end

      case (state)
         IDLE: begin
            if (accept) begin
               shift_nx = data;
               acc_nx   = '0;
               pcw_nx   = '0;
               sym_nx   = '0;
               bit_nx   = '0;
               pre_nx   = '0;
               state_nx = PREAMBLE;
            end
         end
         PREAMBLE: begin
            if (sym_end) begin
               if (pre_cnt == PRE_LAST) begin
                  state_nx = START;
                  pcw_nx   = pcw ^ PI_V;
               end else begin
                  pre_nx = pre_cnt + PRE_W'(1);
               end
            end
         end
         START: begin
            if (sym_end) begin
               state_nx = DATA;
               if (shift[0]) pcw_nx = pcw ^ PI_V;
            end
         end
         DATA: begin
            if (sym_end) begin
               bit_nx   = bit_cnt + 3'd1;
               shift_nx = shift >> 1;
               if (bit_cnt == 3'd7) begin
                  state_nx = STOP;
               end else if (shift[1]) begin
                  pcw_nx = pcw ^ PI_V;
               end
            end
         end
         STOP: begin
            if (sym_end) begin
               if (accept) begin
                  // Back-to-back byte: keep the carrier phase running, skip preamble.
                  shift_nx = data;
                  bit_nx   = '0;
                  pcw_nx   = pcw ^ PI_V;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_psk_modulator.sv
// Randomized bench for psk_modulator; expected carrier derived from a
// per-symbol phase list and the elapsed time since the frame was accepted.
module tb_psk_modulator;

   localparam int PW  = 13;
   localparam int FCW = 512;
   localparam int SC  = 256;
   localparam int P   = 4;

   logic       clk;
   logic       rst_in;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       sig;
   logic       busy;
   logic       sym_stb;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int cyc       = 0;

   logic [7:0] bytes_q[$];
   logic [0:0] exp_q[$];

   psk_modulator #(
      .PHASE_W(PW),
      .FCW(FCW),
      .SYMBOL_CYCLES(SC),
      .PREAMBLE_SYMS(P)
   ) dut (
      .clk(clk),
      .rst_in(rst_in),
      .data(data),
      .valid(valid),
      .ready(ready),
      .sig(sig),
      .busy(busy),
      .sym_stb(sym_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         if (bad_cnt <= 30)
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Per-symbol carrier phase (0 or pi) for the whole burst in bytes_q.
   task automatic build_phases();
      logic       cur;
      logic [7:0] b;
      exp_q.delete();
      cur = 1'b0;
      for (int i = 0; i < P; i++) exp_q.push_back(1'b0);
      for (int i = 0; i < bytes_q.size(); i++) begin
         b   = bytes_q[i];
         cur = ~cur;
         exp_q.push_back(cur);
         for (int j = 0; j < 8; j++) begin
            cur = cur ^ b[j];
            exp_q.push_back(cur);
         end
         exp_q.push_back(cur);
      end
   endtask

   // Starts at a negedge with the DUT idle; ends at a negedge with it idle.
   task automatic run_frames(input bit hold_valid, input int abort_at);
      int   n;
      int   total;
      int   k;
      int   idx;
      logic exp_sig;
      logic stop_last;
      logic in_frame;
      n     = bytes_q.size();
      total = (P + 10 * n) * SC;
      build_phases();
      #1;
      check("idle_ready", ready, 1);
      check("idle_busy", busy, 0);
      valid = 1'b1;
      data  = bytes_q[0];
      @(posedge clk);
      for (int m = 0; m <= total + 1; m++) begin
         @(negedge clk);
         cyc = m;
         if (abort_at >= 0 && m == abort_at) begin
            rst_in = 1'b0;
            valid  = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("abort_sig", sig, 0);
            check("abort_busy", busy, 0);
            check("abort_ready", ready, 0);
            check("abort_stb", sym_stb, 0);
            @(posedge clk);
            @(negedge clk);
            valid  = 1'b0;
            rst_in = 1'b1;
            return;
         end
         if (m == 0 || m > total) begin
            exp_sig = 1'b0;
         end else begin
            k       = (m - 1) * FCW;
            exp_sig = 1'((k >> (PW - 1)) & 1) ^ exp_q[(m - 1) / SC];
         end
         in_frame  = (m < total);
         stop_last = (m + 1 > P * SC) && (((m + 1 - P * SC) % (10 * SC)) == 0);
         check("sig", sig, exp_sig);
         check("busy", busy, in_frame);
         check("ready", ready, in_frame ? stop_last : 1'b1);
         check("sym_stb", sym_stb, in_frame && (m % SC == 0));
         if (in_frame && stop_last) begin
            idx = (m + 1 - P * SC) / (10 * SC);
            if (idx < n) begin
               valid = 1'b1;
               data  = bytes_q[idx];
            end else begin
               valid = 1'b0;
               data  = 8'($urandom);
            end
         end else if (in_frame) begin
            valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
            data  = 8'($urandom);
         end else begin
            valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst_in = 1'b0;
      valid  = 1'b1;
      data   = 8'h3C;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sig", sig, 0);
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_stb", sym_stb, 0);
      rst_in = 1'b1;

      bytes_q = '{8'hA5};
      run_frames(1'b0, -1);

      bytes_q = '{8'h00, 8'hFF};
      run_frames(1'b1, -1);

      bytes_q = '{8'($urandom)};
      run_frames(1'b0, (P + 1 + 3) * SC + 50);
      bytes_q = '{8'($urandom)};
      run_frames(1'b0, -1);

      for (int t = 0; t < 3; t++) begin
         bytes_q.delete();
         for (int i = 0; i < $urandom_range(1, 3); i++) bytes_q.push_back(8'($urandom));
         run_frames(1'($urandom_range(0, 1)), -1);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
